// File: rtl/sd_dac_pkg.sv
// Shared defaults and types for the sigma-delta DAC path.
// Imported by the interpolator, its interface and its input buffer.
package sd_dac_pkg;

    localparam int unsigned SD_DATA_W     = 16;
    localparam int unsigned SD_RATIO_LOG2 = 8;

    typedef logic signed [SD_DATA_W-1:0] sd_sample_t;

    // Accumulator holds x*2^ratio plus a sign guard bit.
    function automatic int unsigned acc_width(int unsigned data_w, int unsigned ratio_log2);
        return data_w + ratio_log2 + 1;
    endfunction

endpackage

// File: rtl/sd_pcm_interp_if.sv
// PCM input handshake plus modulator-side outputs of sd_pcm_interp.
// master = sample source / observer, slave = the interpolator.
interface sd_pcm_interp_if
    import sd_dac_pkg::*;
#(
    parameter int unsigned DATA_W = SD_DATA_W
);

    logic signed [DATA_W-1:0] s_data;
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] sample_out;
    logic                     seg_stb;
    logic                     underrun;
    logic                     underrun_clr;

    modport master (
        output s_data,
        output s_valid,
        output underrun_clr,
        input  s_ready,
        input  sample_out,
        input  seg_stb,
        input  underrun
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  underrun_clr,
        output s_ready,
        output sample_out,
        output seg_stb,
        output underrun
    );

endinterface

// File: rtl/sd_skid_reg.sv
// One-entry input buffer: accepts a sample when empty, frees on a consume strobe.
// Ready depends only on the valid register, never on the input side.
module sd_skid_reg
    import sd_dac_pkg::*;
#(
    parameter int unsigned DATA_W = SD_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] i_data,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic                     i_consume,
    output logic signed [DATA_W-1:0] o_data,
    output logic                     o_valid
);

    logic signed [DATA_W-1:0] r_data;
    logic                     r_valid;

    assign o_ready = !r_valid;
    assign o_data  = r_data;
    assign o_valid = r_valid;

    // Load and consume are exclusive: load needs the slot empty, consume needs it full.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_valid && !r_valid) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_consume && r_valid) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sd_pcm_interp.sv
// Linear PCM interpolator feeding the sigma-delta modulator, one output per clk.
// Define SD_INTERP_LINEAR_EN for linear ramps; otherwise a zero-order hold of x0.
module sd_pcm_interp
    import sd_dac_pkg::*;
#(
    parameter int unsigned DATA_W     = SD_DATA_W,
    parameter int unsigned RATIO_LOG2 = SD_RATIO_LOG2
) (
    input  logic            clk,
    input  logic            reset,
    sd_pcm_interp_if.slave  bus
);

    localparam logic [RATIO_LOG2-1:0] PhaseLast = '1;

    logic [RATIO_LOG2-1:0]    r_phase;
    logic signed [DATA_W-1:0] r_x0;
    logic signed [DATA_W-1:0] r_x1;
    logic signed [DATA_W-1:0] r_out;
    logic                     r_seg_stb;
    logic                     r_underrun;

    logic                     w_wrap;
    logic                     w_ready;
    logic                     w_pend_v;
    logic signed [DATA_W-1:0] w_pend;

    assign w_wrap = (r_phase == PhaseLast);

    sd_skid_reg #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .i_data   (bus.s_data),
        .i_valid  (bus.s_valid),
        .o_ready  (w_ready),
        .i_consume(w_wrap),
        .o_data   (w_pend),
        .o_valid  (w_pend_v)
    );

    assign bus.s_ready    = w_ready;
    assign bus.sample_out = r_out;
    assign bus.seg_stb    = r_seg_stb;
    assign bus.underrun   = r_underrun;

    // Segment control: endpoints shift at the wrap, starved wraps repeat x1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase    <= '0;
            r_x0       <= '0;
            r_x1       <= '0;
            r_seg_stb  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_phase   <= r_phase + 1'b1;
            r_seg_stb <= w_wrap;
            if (w_wrap) begin
                r_x0 <= r_x1;
                if (w_pend_v) begin
                    r_x1 <= w_pend;
                end
            end
            if (w_wrap && !w_pend_v) begin
                r_underrun <= 1'b1;
            end else if (bus.underrun_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

`ifdef SD_INTERP_LINEAR_EN
    localparam int unsigned AccW = acc_width(DATA_W, RATIO_LOG2);

    logic signed [DATA_W:0]   w_delta;
    logic signed [AccW-1:0]   w_delta_ext;
    logic signed [AccW-1:0]   w_acc_seed;
    logic signed [AccW-1:0]   r_acc;
    logic                     w_unused_acc;

    assign w_delta      = {r_x1[DATA_W-1], r_x1} - {r_x0[DATA_W-1], r_x0};
    assign w_delta_ext  = {{RATIO_LOG2{w_delta[DATA_W]}}, w_delta};
    // Seeding with old x1 (= new x0) restarts the ramp exactly on the endpoint.
    assign w_acc_seed   = {r_x1[DATA_W-1], r_x1, {RATIO_LOG2{1'b0}}};
    assign w_unused_acc = ^{r_acc[AccW-1], r_acc[RATIO_LOG2-1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (w_wrap) begin
            r_acc <= w_acc_seed;
        end else begin
            r_acc <= r_acc + w_delta_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
        end else begin
            r_out <= r_acc[DATA_W+RATIO_LOG2-1:RATIO_LOG2];
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
        end else begin
            r_out <= r_x0;
        end
    end
`endif

endmodule
